// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding,
// instruction width and the sequential PC increment.
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } fetch_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect priority mux and target alignment check.
// Ports:
//   trap, jump, branch_taken   redirect requests (trap highest, branch lowest)
//   jump_target, branch_target candidate targets
//   pc                         current fetch PC, passed through when no redirect
//   redir                      any redirect requested
//   next_pc                    PC to load (target, TRAP_VEC if misaligned, else pc)
//   misaligned                 selected target had bits[1:0] != 0
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  TRAP_VEC = 32'h0000_0100
) (
    input  logic             trap,
    input  logic             jump,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [XLEN-1:0]  pc,
    output logic             redir,
    output logic [XLEN-1:0]  next_pc,
    output logic             misaligned
);

    logic [XLEN-1:0] sel_target;

    always_comb begin
        sel_target = branch_target;
        if (trap) begin
            sel_target = TRAP_VEC;
        end else if (jump) begin
            sel_target = jump_target;
        end
    end

    assign redir      = trap | jump | branch_taken;
    assign misaligned = redir && (sel_target[1:0] != 2'b00);

    always_comb begin
        next_pc = pc;
        if (redir) begin
            next_pc = misaligned ? TRAP_VEC : sel_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the architectural fetch PC, issues one imem request
// at a time, hands instructions to decode over valid/ready, and applies
// trap/jump/branch redirects while discarding stale responses.
//
// state  | meaning
// S_BOOT | first cycle after reset, nothing issued yet
// S_REQ  | request presented at pc, waiting for imem_ready_i
// S_WAIT | request accepted, waiting for its response
// S_HOLD | instruction presented to decode, waiting for instr_ready_i
// S_DROP | stale request in flight, swallow its response
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   trap_i, jump_i, branch_taken_i redirect requests with targets
//   imem_req_o/addr_o/ready_i      fetch request channel
//   imem_rvalid_i/rdata_i          fetch response channel
//   instr_valid_o/ready_i/o/pc_o   decode handshake
//   flush_o, misalign_o            one-cycle pulses following a redirect
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VEC = 32'h0000_0100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trap_i,
    input  logic                jump_i,
    input  logic [XLEN-1:0]     jump_target_i,
    input  logic                branch_taken_i,
    input  logic [XLEN-1:0]     branch_target_i,
    output logic                imem_req_o,
    output logic [XLEN-1:0]     imem_addr_o,
    input  logic                imem_ready_i,
    input  logic                imem_rvalid_i,
    input  logic [INSTR_W-1:0]  imem_rdata_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [XLEN-1:0]     instr_pc_o,
    output logic                flush_o,
    output logic                misalign_o
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inflight;

    logic            redir;
    logic [XLEN-1:0] redir_pc;
    logic            redir_misaligned;
    logic            honour;

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_sel (
        .trap          (trap_i),
        .jump          (jump_i),
        .jump_target   (jump_target_i),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .pc            (pc),
        .redir         (redir),
        .next_pc       (redir_pc),
        .misaligned    (redir_misaligned)
    );

    // Redirects are ignored only before the first request exists.
    assign honour      = redir && (state != S_BOOT);
    assign imem_addr_o = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_BOOT;
            pc            <= RESET_PC;
            pc_inflight   <= RESET_PC;
            imem_req_o    <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_pc_o    <= '0;
            flush_o       <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            flush_o    <= honour;
            misalign_o <= honour && redir_misaligned;
            if (honour) begin
                pc <= redir_pc;
            end

            case (state)
                S_BOOT: begin
                    state      <= S_REQ;
                    imem_req_o <= 1'b1;
                end
                S_REQ: begin
                    // Without ready the request simply re-presents at the new pc.
                    if (imem_ready_i) begin
                        pc_inflight <= pc;
                        imem_req_o  <= 1'b0;
                        state       <= honour ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (honour) begin
                        // A response arriving with the redirect is already stale.
                        state      <= imem_rvalid_i ? S_REQ : S_DROP;
                        imem_req_o <= imem_rvalid_i;
                    end else if (imem_rvalid_i) begin
                        instr_o       <= imem_rdata_i;
                        instr_pc_o    <= pc_inflight;
                        instr_valid_o <= 1'b1;
                        pc            <= pc_inflight + XLEN'(PC_INC);
                        state         <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (honour || instr_ready_i) begin
                        instr_valid_o <= 1'b0;
                        imem_req_o    <= 1'b1;
                        state         <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid_i) begin
                        imem_req_o <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                default: begin
                    imem_req_o <= 1'b0;
                    state      <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized traffic, all compared every cycle against a transaction-level
// model (pending request / outstanding fetch / held instruction).
module tb_pc_fetch_ctrl;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_i = 1'b0, jump_i = 1'b0, branch_taken_i = 1'b0;
    logic [31:0] jump_target_i = '0, branch_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o, instr_pc_o;
    logic        flush_o, misalign_o;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .trap_i          (trap_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ready_i    (imem_ready_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit        m_started, m_req, m_out, m_stale, m_hv, m_flush, m_mis;
    bit [31:0] m_pc, m_out_pc, m_hi, m_hpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_started = 0; m_req = 0; m_out = 0; m_stale = 0; m_hv = 0;
        m_flush = 0; m_mis = 0;
        m_pc = RESET_PC; m_out_pc = RESET_PC; m_hi = '0; m_hpc = '0;
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    function automatic void model_step();
        bit        o_out = m_out, o_hv = m_hv, o_req = m_req, o_stale = m_stale;
        bit [31:0] o_pc = m_pc, o_out_pc = m_out_pc;
        bit        redir, mis;
        bit [31:0] tgt;
        if (!m_started) begin
            m_started = 1; m_req = 1; m_flush = 0; m_mis = 0;
            return;
        end
        redir = trap_i | jump_i | branch_taken_i;
        tgt = trap_i ? TRAP_VEC : (jump_i ? jump_target_i : branch_target_i);
        mis = (tgt % 4) != 0;
        if (mis) tgt = TRAP_VEC;
        m_flush = redir;
        m_mis   = redir && mis;
        // Held instruction leaves on handshake or is killed by a redirect.
        if (o_hv && (redir || instr_ready_i)) m_hv = 0;
        // Response to the single outstanding fetch; anything else is ignored.
        if (o_out && imem_rvalid_i) begin
            m_out = 0;
            if (!o_stale && !redir) begin
                m_hv = 1; m_hi = imem_rdata_i; m_hpc = o_out_pc;
                m_pc = o_out_pc + 32'd4;
            end
        end
        if (o_req && imem_ready_i) begin
            m_out = 1; m_out_pc = o_pc; m_stale = redir;
        end else if (o_out && redir) begin
            m_stale = 1;
        end
        if (redir) m_pc = tgt;
        m_req = !m_out && !m_hv;
    endfunction

    task automatic compare_all();
        chk("imem_req",    imem_req_o,    m_req);
        chk("imem_addr",   imem_addr_o,   m_pc);
        chk("instr_valid", instr_valid_o, m_hv);
        if (m_hv) begin
            chk("instr",    instr_o,    m_hi);
            chk("instr_pc", instr_pc_o, m_hpc);
        end
        chk("flush",    flush_o,    m_flush);
        chk("misalign", misalign_o, m_mis);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_redir();
        trap_i = 0; jump_i = 0; branch_taken_i = 0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req",   imem_req_o,    1'b0);
        chk("rst_addr",  imem_addr_o,   RESET_PC);
        chk("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o,       32'h0);
        chk("rst_ipc",   instr_pc_o,    32'h0);
        chk("rst_flush", flush_o,       1'b0);
        chk("rst_mis",   misalign_o,    1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int        req_cyc[$];
        bit [31:0] req_addr[$], got_pc[$], got_instr[$], sent[$];

        model_reset();
        #2;
        do_reset();

        // Streaming fetch with everything ready.
        imem_ready_i = 1; instr_ready_i = 1;
        for (int k = 0; k < 9; k++) begin
            imem_rvalid_i = m_out;
            imem_rdata_i  = 32'hA500_0000 + 32'(k);
            if (m_out) sent.push_back(imem_rdata_i);
            tick();
            if (imem_req_o) begin req_cyc.push_back(k); req_addr.push_back(imem_addr_o); end
            if (instr_valid_o) begin got_pc.push_back(instr_pc_o); got_instr.push_back(instr_o); end
        end
        chk("stream_nreq", req_addr.size(), 3);
        chk("stream_nins", got_pc.size(), 3);
        for (int k = 0; k < 3 && k < req_addr.size() && k < got_pc.size() && k < sent.size(); k++) begin
            chk("stream_addr", req_addr[k], 32'(4 * k));
            chk("stream_pc",   got_pc[k],   32'(4 * k));
            chk("stream_data", got_instr[k], sent[k]);
        end
        if (req_cyc.size() >= 2) chk("stream_gap", req_cyc[1] - req_cyc[0], 3);

        // Decode backpressure while holding the instruction at 0x8.
        imem_rvalid_i = 0; instr_ready_i = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", instr_valid_o, 1'b1);
            chk("bp_pc",    instr_pc_o,    32'h8);
            chk("bp_noreq", imem_req_o,    1'b0);
        end
        instr_ready_i = 1;
        tick();
        chk("bp_release_req",  imem_req_o,  1'b1);
        chk("bp_release_addr", imem_addr_o, 32'hC);

        // Branch during S_WAIT: late response must be swallowed.
        tick();
        branch_taken_i = 1; branch_target_i = 32'h40;
        tick();
        chk("br_flush", flush_o, 1'b1);
        clear_redir();
        imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 0;
        chk("br_drop_valid", instr_valid_o, 1'b0);
        chk("br_addr",       imem_addr_o,   32'h40);
        chk("br_req",        imem_req_o,    1'b1);

        // All three redirects together: trap wins.
        imem_ready_i = 0;
        trap_i = 1; jump_i = 1; branch_taken_i = 1; jump_target_i = 32'h80;
        tick();
        clear_redir();
        chk("prio_addr", imem_addr_o, TRAP_VEC);
        chk("prio_mis",  misalign_o,  1'b0);

        // Misaligned jump goes to the trap vector.
        jump_i = 1; jump_target_i = 32'h42;
        tick();
        clear_redir();
        chk("mis_addr",  imem_addr_o, TRAP_VEC);
        chk("mis_pulse", misalign_o,  1'b1);
        chk("mis_flush", flush_o,     1'b1);
        tick();
        chk("mis_once",   misalign_o, 1'b0);
        chk("flush_once", flush_o,    1'b0);

        // PC wrap past the top of the address space.
        jump_i = 1; jump_target_i = 32'hFFFF_FFFC;
        tick();
        clear_redir();
        imem_ready_i = 1;
        tick();
        imem_ready_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'h1234_5678;
        tick();
        imem_rvalid_i = 0;
        chk("wrap_ipc", instr_pc_o, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", imem_addr_o, 32'h0);

        // Reach S_HOLD with pc = 0x20, then reset.
        jump_i = 1; jump_target_i = 32'h1C;
        tick();
        clear_redir();
        imem_ready_i = 1;
        tick();
        imem_ready_i = 0; imem_rvalid_i = 1; instr_ready_i = 0;
        tick();
        imem_rvalid_i = 0;
        chk("hold_pc", imem_addr_o, 32'h20);
        do_reset();
        tick();
        chk("post_rst_addr", imem_addr_o, 32'h0);
        chk("post_rst_req",  imem_req_o,  1'b1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            trap_i          = ($urandom_range(99) < 3);
            jump_i          = ($urandom_range(99) < 6);
            branch_taken_i  = ($urandom_range(99) < 6);
            jump_target_i   = $urandom & (($urandom_range(3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            branch_target_i = $urandom & (($urandom_range(3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            imem_ready_i    = ($urandom_range(99) < 70);
            imem_rvalid_i   = m_out ? ($urandom_range(1) == 1) : ($urandom_range(99) < 5);
            imem_rdata_i    = $urandom;
            instr_ready_i   = ($urandom_range(99) < 60);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequences the program-counter register and instruction fetch for the single-issue core.
- Issues fetch requests to instruction memory and tracks the one outstanding request.
- Presents fetched instructions to decode through a valid/ready handshake.
- Applies redirects (trap, jump, taken branch) with a fixed priority, and discards stale fetch responses.
- Sits between the PC register/adder and the imem port; it owns the architectural fetch PC.

Parameters:
XLEN, 32, width of PC and target buses
RESET_PC, 32'h0000_0000, fetch address after reset
TRAP_VEC, 32'h0000_0100, redirect address for trap_i and misaligned targets

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
trap_i  input  1  trap redirect request (highest priority)
jump_i  input  1  jump redirect request
jump_target_i  input  XLEN  jump target
branch_taken_i  input  1  taken-branch redirect request (lowest priority)
branch_target_i  input  XLEN  branch target
imem_req_o  output  1  fetch request valid
imem_addr_o  output  XLEN  fetch address
imem_ready_i  input  1  imem accepts request this cycle
imem_rvalid_i  input  1  fetch response valid
imem_rdata_i  input  32  fetch response data
instr_valid_o  output  1  instruction available to decode
instr_ready_i  input  1  decode accepts instruction
instr_o  output  32  fetched instruction
instr_pc_o  output  XLEN  PC of instr_o
flush_o  output  1  one-cycle pulse: pipeline must discard younger work
misalign_o  output  1  one-cycle pulse: redirect target had bits[1:0] != 0

Behaviour:
- Reset (async assert, sync deassert use):
  - pc = RESET_PC, state = S_BOOT.
  - All outputs 0, except imem_addr_o = RESET_PC.
- States:
  - S_BOOT: goes to S_REQ on the first cycle after reset release.
  - S_REQ: drives imem_req_o = 1 and imem_addr_o = pc. When imem_ready_i = 1, latch pc_inflight = pc and go to S_WAIT.
  - S_WAIT: on imem_rvalid_i = 1, register instr_o = imem_rdata_i, instr_pc_o = pc_inflight and instr_valid_o = 1; set pc = pc_inflight + 4 (mod 2^XLEN, carry dropped); go to S_HOLD.
  - S_HOLD: instr_valid_o and its data stay stable until instr_valid_o & instr_ready_i. On that handshake cycle, clear instr_valid_o and go to S_REQ.
  - S_DROP: wait for imem_rvalid_i, discard the data, then go to S_REQ.
- Best-case latency: request accepted at cycle N, response at N+1, instr_valid_o at N+2, next request at N+3 if decode is ready.
- Redirect:
  - redir = trap_i | jump_i | branch_taken_i.
  - Target priority: trap_i -> TRAP_VEC, else jump_i -> jump_target_i, else branch_target_i.
  - If the selected target[1:0] != 0, the target becomes TRAP_VEC and misalign_o pulses on the next cycle.
  - A redirect is honoured in any state except S_BOOT. pc = target, and flush_o pulses on the next cycle.
- Redirect per state:
  - S_REQ with imem_ready_i = 0: request withdrawn; imem_addr_o shows the new pc next cycle; stay in S_REQ.
  - S_REQ with imem_ready_i = 1 on the same cycle: the old-address request is in flight; go to S_DROP.
  - S_WAIT with no rvalid: go to S_DROP.
  - S_WAIT with rvalid on the same cycle: discard the response, go to S_REQ.
  - S_HOLD: clear instr_valid_o (the held instruction is dropped even if instr_ready_i = 1 that cycle), go to S_REQ.
  - S_DROP: update pc, stay in S_DROP.
- Only one outstanding imem request at any time; imem_req_o is never asserted in S_WAIT or S_DROP.
- imem_rvalid_i in S_REQ or S_HOLD is a protocol error: ignored, no state change.
- Reset asserted mid-operation: immediate return to reset values; any in-flight response is lost.

Decomposition:
- Shared package pc_ctrl_pkg holds:
  - state enum (S_BOOT, S_REQ, S_WAIT, S_HOLD, S_DROP)
  - INSTR_W = 32
  - PC_INC = 4
- One sub-module, pc_next_sel (combinational):
  - inputs: redirect requests, targets, current pc
  - outputs: redir, selected target, misaligned flag
  - contains the priority mux and alignment check.

Test Plan:
- Reset release, imem always ready, rvalid one cycle after accept, instr_ready_i = 1 -> request addresses 0x0, 0x4, 0x8, one per 3 cycles; instr_pc_o = 0x0, 0x4, 0x8; instr_o matches rdata.
- instr_ready_i = 0 for 5 cycles while instr_valid_o = 1 -> instr_o/instr_pc_o stable, no new imem_req_o; the next request goes out the cycle after ready returns.
- branch_taken_i with target 0x40 during S_WAIT -> flush_o pulse; the late response is discarded (instr_valid_o stays 0); next request address is 0x40.
- trap_i, jump_i and branch_taken_i asserted together, jump target 0x80 -> next request address 0x100; misalign_o = 0.
- jump_i with target 0x42 -> next request address 0x100; misalign_o and flush_o each pulse once.
- rst_n dropped while in S_HOLD with pc = 0x20 -> outputs cleared immediately; after release, first request address is 0x0.
